ghost_sprite_fetch: RTL and testbench

GHOST_SPRITE_FETCH -- requirements
Module: ghost_sprite_fetch

---
 rtl/ghost_render_pkg.sv | 31 +++
 rtl/ghost_sprite_sel.sv | 31 +++
 rtl/ghost_sprite_fetch.sv | 148 ++++++++++++++
 tb/tb_ghost_sprite_fetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_render_pkg.sv
// ghost_render_pkg
//   Shared constants, the fetch FSM state type and the sprite ROM word-address
//   helper used by the ghost sprite line fetcher.
//   Sprite ROM layout: 16 sprites x 24 rows x 3 words. Each 16-bit word holds
//   8 pixels at 2 bits per pixel, with the leftmost pixel in the low bits.
package ghost_render_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [9:0]  SPRITE_W         = 10'd24;  // pixels per row and rows per sprite
  localparam logic [1:0]  ROW_WORDS        = 2'd3;
  localparam logic [10:0] WORDS_PER_SPRITE = 11'd72;
  localparam logic [9:0]  Y_OFFSET         = 10'd6;

  localparam logic [9:0]  PLAYFIELD_XMIN   = 10'd72;
  localparam logic [9:0]  PLAYFIELD_XMAX   = 10'd408;  // exclusive

  localparam logic [3:0]  SEL_FRIGHT_BASE  = 4'd8;
  localparam logic [3:0]  SEL_FLASH_BASE   = 4'd10;
  localparam logic [3:0]  SEL_DEAD_BASE    = 4'd12;

  // First ROM word of a given sprite row. Max value is 15*72 + 23*3 = 1149.
  function automatic logic [10:0] word_base(input logic [3:0] sel, input logic [4:0] row);
    return ({7'd0, sel} * WORDS_PER_SPRITE) + ({6'd0, row} * {9'd0, ROW_WORDS});
  endfunction

endpackage

// File: rtl/ghost_sprite_sel.sv
// ghost_sprite_sel
//   Maps the ghost controller state to a 4-bit sprite ROM select.
//   Ports:
//     sprite_i  - animation frame index (only bits [2:0] carry information)
//     fright_i  - 0 normal, 1 blue, 2 white flash
//     dead_i    - eyes-only rendering; takes priority over fright_i
//     sel_o     - sprite select 0..15
module ghost_sprite_sel
  import ghost_render_pkg::*;
(
  input  logic [3:0] sprite_i,
  input  logic [3:0] fright_i,
  input  logic       dead_i,
  output logic [3:0] sel_o
);

  logic unused_sprite_msb;
  assign unused_sprite_msb = sprite_i[3];

  always_comb begin
    sel_o = {1'b0, sprite_i[2:0]};
    if (dead_i) begin
      sel_o = SEL_DEAD_BASE + {2'b00, sprite_i[2:1]};
    end else if (fright_i == 4'd1) begin
      sel_o = SEL_FRIGHT_BASE + {3'b000, sprite_i[0]};
    end else if (fright_i == 4'd2) begin
      sel_o = SEL_FLASH_BASE + {3'b000, sprite_i[0]};
    end
  end

endmodule

// File: rtl/ghost_sprite_fetch.sv
// ghost_sprite_fetch
//   During horizontal blank, fetches the three ROM words of the ghost sprite
//   row that intersects fetch_line into a 48-bit line buffer. During the
//   visible line, looks up the pixel under DrawX and presents it registered.
//   Ports:
//     Clk, Reset_n            - clock, asynchronous active-low reset
//     line_start, fetch_line  - fetch request pulse and the screen line it targets
//     DrawX                   - current pixel column
//     ghostPosX, ghostPosY    - ghost top-left position
//     ghost_sprite, ghost_is_frightened, is_ghost_dead - sprite select inputs
//     rom_addr, rom_data      - sprite ROM port, data valid 1 Clk after address
//     busy                    - fetch in progress
//     ghost_pix, is_ghost     - palette index of current pixel (0 transparent)
module ghost_sprite_fetch
  import ghost_render_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        line_start,
  input  logic [9:0]  fetch_line,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  ghostPosX,
  input  logic [9:0]  ghostPosY,
  input  logic [3:0]  ghost_sprite,
  input  logic [3:0]  ghost_is_frightened,
  input  logic        is_ghost_dead,
  output logic [10:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        busy,
  output logic        is_ghost,
  output logic [1:0]  ghost_pix
);

  fetch_state_e state_q;
  logic [1:0]   w_q;
  logic [10:0]  rom_addr_q;
  logic         busy_q;
  logic         row_valid_q;
  logic [47:0]  line_buf_q;
  logic [9:0]   posx_q;
  logic [1:0]   ghost_pix_q;
  logic         is_ghost_q;

  logic [3:0]   sel_d;
  logic [9:0]   row_d;
  logic         row_ok_d;
  logic [10:0]  base_d;
  logic [9:0]   pix_ofs_d;
  logic [5:0]   pix_idx_d;
  logic         pix_ok_d;
  logic [1:0]   pix_d;

  ghost_sprite_sel u_sel (
    .sprite_i (ghost_sprite),
    .fright_i (ghost_is_frightened),
    .dead_i   (is_ghost_dead),
    .sel_o    (sel_d)
  );

  always_comb begin
    // A line above the sprite underflows to a large value and fails row_ok_d.
    row_d     = fetch_line - ghostPosY - Y_OFFSET;
    row_ok_d  = (row_d < SPRITE_W);
    base_d    = word_base(sel_d, row_d[4:0]);

    // Pixel p sits at line buffer bits [2p+1:2p], since word p/8 occupies
    // bits [16*(p/8)+15 : 16*(p/8)] and the pixel is at 2*(p%8) within it.
    pix_ofs_d = DrawX - posx_q;
    pix_idx_d = {pix_ofs_d[4:0], 1'b0};
    pix_ok_d  = (pix_ofs_d < SPRITE_W) && (DrawX >= PLAYFIELD_XMIN) &&
                (DrawX < PLAYFIELD_XMAX) && row_valid_q && !busy_q;
    pix_d     = '0;
    if (pix_ok_d) begin
      pix_d = line_buf_q[pix_idx_d +: 2];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      row_valid_q <= 1'b0;
      line_buf_q  <= '0;
      posx_q      <= '0;
      ghost_pix_q <= '0;
      is_ghost_q  <= 1'b0;
    end else begin
      ghost_pix_q <= pix_d;
      is_ghost_q  <= (pix_d != '0);

      // A request in any state, including mid-fetch, restarts from word 0.
      // rom_addr is loaded with word 0 here so that each address is on the
      // bus for the whole ISSUE cycle that owns it.
      if (line_start) begin
        posx_q      <= ghostPosX;
        row_valid_q <= 1'b0;
        w_q         <= '0;
        if (row_ok_d) begin
          state_q    <= ST_ISSUE;
          busy_q     <= 1'b1;
          rom_addr_q <= base_d;
        end else begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_ISSUE: begin
            // Data on rom_data belongs to the address of the previous cycle.
            case (w_q)
              2'd1:    line_buf_q[15:0]  <= rom_data;
              2'd2:    line_buf_q[31:16] <= rom_data;
              default: ;
            endcase
            if (w_q == ROW_WORDS - 2'd1) begin
              state_q <= ST_DRAIN;
            end else begin
              w_q        <= w_q + 2'd1;
              rom_addr_q <= rom_addr_q + 11'd1;
            end
          end
          ST_DRAIN: begin
            line_buf_q[47:32] <= rom_data;
            row_valid_q       <= 1'b1;
            busy_q            <= 1'b0;
            w_q               <= '0;
            state_q           <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;
  assign ghost_pix = ghost_pix_q;
  assign is_ghost  = is_ghost_q;

endmodule

// File: tb/tb_ghost_sprite_fetch.sv
// Scoreboard bench for ghost_sprite_fetch: stimulus queues expected ROM
// addresses and pixels, monitors compare them as the DUT presents them.
module tb_ghost_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  fetch_line = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  ghostPosX = '0;
  logic [9:0]  ghostPosY = '0;
  logic [3:0]  ghost_sprite = '0;
  logic [3:0]  ghost_is_frightened = '0;
  logic        is_ghost_dead = 1'b0;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        is_ghost;
  logic [1:0]  ghost_pix;

  ghost_sprite_fetch dut (
    .Clk                 (Clk),
    .Reset_n             (Reset_n),
    .line_start          (line_start),
    .fetch_line          (fetch_line),
    .DrawX               (DrawX),
    .ghostPosX           (ghostPosX),
    .ghostPosY           (ghostPosY),
    .ghost_sprite        (ghost_sprite),
    .ghost_is_frightened (ghost_is_frightened),
    .is_ghost_dead       (is_ghost_dead),
    .rom_addr            (rom_addr),
    .rom_data            (rom_data),
    .busy                (busy),
    .is_ghost            (is_ghost),
    .ghost_pix           (ghost_pix)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_total = 0;

  logic [10:0] addr_exp_q[$];
  logic [1:0]  pix_exp_q[$];

  logic        rom_solid = 1'b0;
  logic        px_vld = 1'b0;
  logic        px_vld_d = 1'b0;
  logic [10:0] cur_base = '0;
  logic        cur_valid = 1'b0;
  logic        cur_solid = 1'b0;
  logic [9:0]  cur_px = '0;

  logic [10:0] mon_addr;
  logic [1:0]  mon_pix;

  // ROM contents: a scrambled pattern with a mix of transparent and opaque
  // pixels, or a fully opaque (palette 3) row when solid is set.
  function automatic logic [15:0] rom_word(input logic [10:0] a, input logic solid);
    logic [15:0] h;
    if (solid) return 16'hFFFF;
    h = {5'd0, a} * 16'd40503;
    return h ^ 16'h1F2E;
  endfunction

  always @(posedge Clk) rom_data <= rom_word(rom_addr, rom_solid);

  function automatic logic [1:0] exp_pix(input logic [9:0] x);
    logic [9:0]  p;
    logic [15:0] wd;
    p = x - cur_px;
    if (!cur_valid || p >= 10'd24 || x < 10'd72 || x >= 10'd408) return 2'd0;
    wd = rom_word(cur_base + {9'd0, p[4:3]}, cur_solid);
    return wd[{p[2:0], 1'b0} +: 2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors
  always @(posedge Clk) px_vld_d <= px_vld;

  always @(negedge Clk) begin
    if (busy) begin
      busy_total++;
      if (addr_exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL addr_extra: rom_addr %0d seen with no expected address queued at %0t",
                 rom_addr, $time);
      end else begin
        mon_addr = addr_exp_q.pop_front();
        check("rom_addr", 32'(rom_addr), 32'(mon_addr));
      end
    end
    if (px_vld_d) begin
      if (pix_exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pix_extra: ghost_pix %0d with no expected pixel queued", ghost_pix);
      end else begin
        mon_pix = pix_exp_q.pop_front();
        check("ghost_pix", 32'(ghost_pix), 32'(mon_pix));
        check("is_ghost", 32'(is_ghost), 32'(mon_pix != 2'd0));
      end
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_fetch(input logic [10:0] base);
    addr_exp_q.push_back(base);
    addr_exp_q.push_back(base + 11'd1);
    addr_exp_q.push_back(base + 11'd2);
    addr_exp_q.push_back(base + 11'd2);  // held through DRAIN
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("fetch_timeout_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_fetch(input logic [9:0] line, input logic [9:0] px, input logic [9:0] py,
                          input logic [3:0] spr, input logic [3:0] fr, input logic dead,
                          input logic solid, input logic [10:0] base, input logic valid);
    int b0;
    tick();
    rom_solid           = solid;
    fetch_line          = line;
    ghostPosX           = px;
    ghostPosY           = py;
    ghost_sprite        = spr;
    ghost_is_frightened = fr;
    is_ghost_dead       = dead;
    line_start          = 1'b1;
    if (valid) push_fetch(base);
    b0 = busy_total;
    tick();
    line_start = 1'b0;
    // Position inputs are scrambled to show the fetch uses latched values.
    ghostPosX  = '0;
    ghostPosY  = 10'h3FF;
    wait_idle();
    check("busy_cycles", 32'(busy_total - b0), valid ? 32'd4 : 32'd0);
    check("addr_pending", 32'(addr_exp_q.size()), 32'd0);
    cur_base  = base;
    cur_valid = valid;
    cur_solid = solid;
    cur_px    = px;
  endtask

  task automatic scan(input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      tick();
      DrawX  = 10'(x);
      px_vld = 1'b1;
      pix_exp_q.push_back(exp_pix(10'(x)));
    end
    tick();
    px_vld = 1'b0;
    tick();
    tick();
    check("pix_pending", 32'(pix_exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    Reset_n = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_ghost_pix", 32'(ghost_pix), 32'd0);
    check("reset_is_ghost", 32'(is_ghost), 32'd0);
    Reset_n = 1'b1;
    tick();
    cur_valid = 1'b0;
    scan(70, 80);

    // Normal sprite 2, row 0 -> 144
    do_fetch(10'd234, 10'd228, 10'd228, 4'd2, 4'd0, 1'b0, 1'b0, 11'd144, 1'b1);
    scan(224, 255);
    // Last valid row 23 -> 213
    do_fetch(10'd257, 10'd228, 10'd228, 4'd2, 4'd0, 1'b0, 1'b0, 11'd213, 1'b1);
    scan(226, 254);
    // Row 24 and underflow: no fetch, nothing shown
    do_fetch(10'd258, 10'd228, 10'd228, 4'd2, 4'd0, 1'b0, 1'b0, 11'd0, 1'b0);
    scan(226, 254);
    do_fetch(10'd233, 10'd228, 10'd228, 4'd2, 4'd0, 1'b0, 1'b0, 11'd0, 1'b0);
    scan(226, 254);

    // Select priority: flash sprite 5 -> sel 11; dead over blue, sprite 6 -> sel 15;
    // blue sprite 4 -> sel 8
    do_fetch(10'd234, 10'd100, 10'd228, 4'd5, 4'd2, 1'b0, 1'b0, 11'd792, 1'b1);
    scan(98, 126);
    do_fetch(10'd234, 10'd100, 10'd228, 4'd6, 4'd1, 1'b1, 1'b0, 11'd1080, 1'b1);
    scan(98, 126);
    do_fetch(10'd234, 10'd100, 10'd228, 4'd4, 4'd1, 1'b0, 1'b0, 11'd576, 1'b1);
    scan(98, 126);

    // Playfield clipping with an opaque row
    do_fetch(10'd234, 10'd60, 10'd228, 4'd0, 4'd0, 1'b0, 1'b1, 11'd0, 1'b1);
    scan(56, 90);
    do_fetch(10'd234, 10'd400, 10'd228, 4'd0, 4'd0, 1'b0, 1'b1, 11'd0, 1'b1);
    scan(396, 430);

    // Restart during ISSUE at w=1: sprite 1 row 0 (72) replaced by sprite 3 row 1 (219)
    tick();
    rom_solid = 1'b0;
    fetch_line = 10'd234; ghostPosX = 10'd150; ghostPosY = 10'd228;
    ghost_sprite = 4'd1; ghost_is_frightened = 4'd0; is_ghost_dead = 1'b0;
    line_start = 1'b1;
    addr_exp_q.push_back(11'd72);
    addr_exp_q.push_back(11'd73);
    b0 = busy_total;
    tick();
    line_start = 1'b0;
    tick();
    fetch_line = 10'd235; ghostPosX = 10'd140; ghost_sprite = 4'd3;
    line_start = 1'b1;
    push_fetch(11'd219);
    tick();
    line_start = 1'b0;
    wait_idle();
    check("abort_busy_cycles", 32'(busy_total - b0), 32'd6);
    check("abort_addr_pending", 32'(addr_exp_q.size()), 32'd0);
    cur_base = 11'd219; cur_valid = 1'b1; cur_solid = 1'b0; cur_px = 10'd140;
    scan(136, 168);

    // Reset during DRAIN: sprite 7 row 6 -> 522
    tick();
    fetch_line = 10'd240; ghostPosX = 10'd200; ghostPosY = 10'd228;
    ghost_sprite = 4'd7;
    line_start = 1'b1;
    push_fetch(11'd522);
    b0 = busy_total;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    tick();
    @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_rom_addr", 32'(rom_addr), 32'd0);
    check("midreset_ghost_pix", 32'(ghost_pix), 32'd0);
    check("midreset_is_ghost", 32'(is_ghost), 32'd0);
    check("midreset_busy_cycles", 32'(busy_total - b0), 32'd4);
    check("midreset_addr_pending", 32'(addr_exp_q.size()), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cur_valid = 1'b0;
    scan(196, 228);
    do_fetch(10'd240, 10'd200, 10'd228, 4'd7, 4'd0, 1'b0, 1'b0, 11'd522, 1'b1);
    scan(196, 228);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
